// File: rtl/prbs8_chk.sv
// prbs8_chk: serial PRBS checker. It acquires the sequence in three steps (hunt, sync,
// lock), then free-runs and counts bit errors. Define PRBS8_CHK_PERIOD_MEAS_EN to add period measurement.
module prbs8_chk (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mask,
  input  logic        in,
  input  logic        en,
  input  logic        clr,
  output logic        lock,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [8:0]  period,
  output logic        period_vld
);

  localparam int unsigned W_H          = 8;
  localparam int unsigned W_BIT        = 3;
  localparam int unsigned W_MATCH      = 5;
  localparam int unsigned W_MM         = 2;
  localparam int unsigned W_ERR        = 16;
  localparam int unsigned W_PER        = 9;
  localparam int unsigned HUNT_BITS    = 8;
  localparam int unsigned LOCK_MATCHES = 16;
  localparam int unsigned MAX_MISSES   = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [W_H-1:0]     h, h_nx;
  logic [W_BIT-1:0]   bit_cnt, bit_nx;
  logic [W_MATCH-1:0] match_cnt, match_nx;
  logic [W_MM-1:0]    mm_cnt, mm_nx;
  logic               lock_nx;
  logic               err_nx;
  logic [W_ERR-1:0]   err_cnt_nx;
  logic               pred_c;

  // Expected next bit from the last eight received (or predicted) bits.
  assign pred_c = ^(h & mask);

  // Acquisition / tracking next-state logic.
  always_comb begin
    state_nx   = state;
    h_nx       = h;
    bit_nx     = bit_cnt;
    match_nx   = match_cnt;
    mm_nx      = mm_cnt;
    lock_nx    = lock;
    err_nx     = 1'b0;
    err_cnt_nx = err_cnt;
    if (clr) begin
      state_nx   = HUNT;
      h_nx       = '0;
      bit_nx     = '0;
      match_nx   = '0;
      mm_nx      = '0;
      lock_nx    = 1'b0;
      err_cnt_nx = '0;
    end else if (en) begin
      case (state)
        HUNT: begin
          h_nx = {h[W_H-2:0], in};
          if (bit_cnt == W_BIT'(HUNT_BITS - 1)) begin
            state_nx = SYNC;
            bit_nx   = '0;
            match_nx = '0;
          end else begin
            bit_nx = W_BIT'(bit_cnt + 1'b1);
          end
        end
        SYNC: begin
          h_nx = {h[W_H-2:0], in};
          // An all-zero history predicts zeros forever; never accept it as a match.
          if ((in == pred_c) && (h != '0)) begin
            if (match_cnt == W_MATCH'(LOCK_MATCHES - 1)) begin
              state_nx = LOCKED;
              lock_nx  = 1'b1;
              match_nx = '0;
              mm_nx    = '0;
            end else begin
              match_nx = W_MATCH'(match_cnt + 1'b1);
            end
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a line error is not fed back into the history.
          h_nx = {h[W_H-2:0], pred_c};
          if (in != pred_c) begin
            err_nx = 1'b1;
            if (err_cnt != '1) err_cnt_nx = W_ERR'(err_cnt + 1'b1);
            if (mm_cnt == W_MM'(MAX_MISSES - 1)) begin
              state_nx = HUNT;
              bit_nx   = '0;
              mm_nx    = '0;
              lock_nx  = 1'b0;
            end else begin
              mm_nx = W_MM'(mm_cnt + 1'b1);
            end
          end else begin
            mm_nx = '0;
          end
        end
        default: begin
          state_nx = HUNT;
          bit_nx   = '0;
          match_nx = '0;
          mm_nx    = '0;
          lock_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      h         <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      mm_cnt    <= '0;
      lock      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nx;
      h         <= h_nx;
      bit_cnt   <= bit_nx;
      match_cnt <= match_nx;
      mm_cnt    <= mm_nx;
      lock      <= lock_nx;
      err       <= err_nx;
      err_cnt   <= err_cnt_nx;
    end
  end

`ifdef PRBS8_CHK_PERIOD_MEAS_EN
  localparam logic [W_PER-1:0] PER_MAX = '1;

  logic [W_H-1:0]   h0, h0_nx;
  logic [W_PER-1:0] per_cnt, per_cnt_nx, period_nx;
  logic             period_vld_nx;

  // Period: count locked bits until the free-running history returns to its lock-entry value.
  always_comb begin
    h0_nx         = h0;
    per_cnt_nx    = per_cnt;
    period_nx     = period;
    period_vld_nx = period_vld;
    if ((state == LOCKED) && (state_nx != LOCKED)) begin
      period_vld_nx = 1'b0;
    end else if ((state != LOCKED) && (state_nx == LOCKED)) begin
      h0_nx      = h_nx;
      per_cnt_nx = '0;
    end else if ((state == LOCKED) && en) begin
      if (per_cnt == PER_MAX) begin
        period_vld_nx = 1'b0;
      end else if (h_nx == h0) begin
        period_nx     = W_PER'(per_cnt + 1'b1);
        period_vld_nx = 1'b1;
        per_cnt_nx    = '0;
      end else begin
        per_cnt_nx = W_PER'(per_cnt + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h0         <= '0;
      per_cnt    <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      h0         <= h0_nx;
      per_cnt    <= per_cnt_nx;
      period     <= period_nx;
      period_vld <= period_vld_nx;
    end
  end
`else
  assign period     = '0;
  assign period_vld = 1'b0;
`endif

endmodule
